// File: rtl/commit_trace_checker_if.sv
// Retirement port of the commit trace checker.
// The writeback stage drives master; the checker consumes slave.
interface commit_trace_checker_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              commit_valid;
    logic [ADDR_W-1:0] commit_pc;
    logic              commit_wr;
    logic [4:0]        commit_rd;
    logic [DATA_W-1:0] commit_data;

    modport master (
        output commit_valid, commit_pc, commit_wr,
        output commit_rd, commit_data
    );

    modport slave (
        input commit_valid, commit_pc, commit_wr,
        input commit_rd, commit_data
    );
endinterface

// File: rtl/commit_trace_checker.sv
// Commit monitor: compares each retired instruction with a stored
// expected trace and reports mismatches, pass, fail or timeout.
module commit_trace_checker #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int DEPTH   = 64,
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 8,
    localparam int IDX_W  = $clog2(DEPTH) + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_en,
    input  logic [IDX_W-2:0]  load_idx,
    input  logic [ADDR_W-1:0] load_pc,
    input  logic              load_wr,
    input  logic [4:0]        load_rd,
    input  logic [DATA_W-1:0] load_data,
    input  logic [IDX_W-1:0]  trace_len,
    input  logic              start,
    commit_trace_checker_if.slave cif,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [CNT_W-1:0]  mismatch_cnt,
    output logic [IDX_W-1:0]  first_fail,
    output logic [IDX_W-1:0]  entry_idx
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0] DEPTH_L = IDX_W'(DEPTH);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IDX_W-1:0]  len_q, len_d;
    logic [IDX_W-1:0]  ff_q, ff_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TW-1:0]     idle_q, idle_d;
    logic              to_q, to_d;

    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic              wr_mem   [DEPTH];
    logic [4:0]        rd_mem   [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];

    logic [IDX_W-2:0]  rd_idx;
    logic              exp_wr, act_wr, match;

    // Trace storage is deliberately left out of reset so a trace survives it.
    always_ff @(posedge clock) begin
        if (load_en && state_q != RUN && {1'b0, load_idx} < DEPTH_L) begin
            pc_mem[load_idx]   <= load_pc;
            wr_mem[load_idx]   <= load_wr;
            rd_mem[load_idx]   <= load_rd;
            data_mem[load_idx] <= load_data;
        end
    end

    // A write to XZR is architecturally a no-op, so compare it as wr=0.
    always_comb begin
        rd_idx = idx_q[IDX_W-2:0];
        exp_wr = wr_mem[rd_idx] && (rd_mem[rd_idx] != 5'd31);
        act_wr = cif.commit_wr && (cif.commit_rd != 5'd31);
        match  = (pc_mem[rd_idx] == cif.commit_pc) && (exp_wr == act_wr)
              && (!act_wr || ((rd_mem[rd_idx] == cif.commit_rd)
              && (data_mem[rd_idx] == cif.commit_data)));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            ff_q    <= '1;
            cnt_q   <= '0;
            idle_q  <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            ff_q    <= ff_d;
            cnt_q   <= cnt_d;
            idle_q  <= idle_d;
            to_q    <= to_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        ff_d    = ff_q;
        cnt_d   = cnt_q;
        idle_d  = idle_q;
        to_d    = to_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    len_d   = (trace_len > DEPTH_L) ? DEPTH_L : trace_len;
                    idx_d   = '0;
                    cnt_d   = '0;
                    ff_d    = '1;
                    idle_d  = '0;
                    to_d    = 1'b0;
                end
            end
            RUN: begin
                if (idx_q == len_q) begin
                    state_d = DONE;
                end else if (cif.commit_valid) begin
                    idx_d  = idx_q + 1'b1;
                    idle_d = '0;
                    if (!match) begin
                        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                        if (ff_q == '1) ff_d = idx_q;
                    end
                end else if (idle_q == TO_LAST) begin
                    state_d = DONE;
                    to_d    = 1'b1;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy         = (state_q == RUN);
    assign done         = (state_q == DONE);
    assign pass         = done && (cnt_q == '0) && !to_q;
    assign timeout      = to_q;
    assign mismatch_cnt = cnt_q;
    assign first_fail   = ff_q;
    assign entry_idx    = idx_q;
endmodule

// File: tb/tb_commit_trace_checker.sv
// Directed bench for commit_trace_checker with hand-computed
// expectations checked by immediate assertions.
module tb_commit_trace_checker;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int DEPTH = 512;
    localparam int IW = $clog2(DEPTH) + 1;

    logic          clock = 1'b0;
    logic          reset;
    logic          load_en;
    logic [IW-2:0] load_idx;
    logic [AW-1:0] load_pc;
    logic          load_wr;
    logic [4:0]    load_rd;
    logic [DW-1:0] load_data;
    logic [IW-1:0] trace_len;
    logic          start;
    logic          busy, done, pass, timeout;
    logic [7:0]    mismatch_cnt;
    logic [IW-1:0] first_fail, entry_idx;

    int checks = 0;
    int failures = 0;

    commit_trace_checker_if #(.ADDR_W(AW), .DATA_W(DW)) cif ();

    commit_trace_checker #(
        .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH),
        .TIMEOUT(16), .CNT_W(8)
    ) dut (
        .clock(clock), .reset(reset),
        .load_en(load_en), .load_idx(load_idx),
        .load_pc(load_pc), .load_wr(load_wr),
        .load_rd(load_rd), .load_data(load_data),
        .trace_len(trace_len), .start(start),
        .cif(cif),
        .busy(busy), .done(done), .pass(pass),
        .timeout(timeout), .mismatch_cnt(mismatch_cnt),
        .first_fail(first_fail), .entry_idx(entry_idx)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int idx, input logic [63:0] pc,
                        input logic wr, input logic [4:0] rd,
                        input logic [63:0] data);
        load_en   = 1'b1;
        load_idx  = idx[IW-2:0];
        load_pc   = pc;
        load_wr   = wr;
        load_rd   = rd;
        load_data = data;
        tick();
        load_en = 1'b0;
    endtask

    task automatic go(input int len);
        trace_len = len[IW-1:0];
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic commit(input logic [63:0] pc, input logic wr,
                          input logic [4:0] rd, input logic [63:0] data);
        cif.commit_valid = 1'b1;
        cif.commit_pc    = pc;
        cif.commit_wr    = wr;
        cif.commit_rd    = rd;
        cif.commit_data  = data;
        tick();
        cif.commit_valid = 1'b0;
    endtask

    task automatic good_trace();
        commit(64'h00, 1'b0, 5'd0, 64'd0);
        commit(64'h18, 1'b1, 5'd2, 64'd26);
        commit(64'h1C, 1'b1, 5'd30, 64'h20);
    endtask

    initial begin
        reset = 1'b1;
        load_en = 1'b0; load_idx = '0; load_pc = '0;
        load_wr = 1'b0; load_rd = '0; load_data = '0;
        trace_len = '0; start = 1'b0;
        cif.commit_valid = 1'b0; cif.commit_pc = '0;
        cif.commit_wr = 1'b0; cif.commit_rd = '0; cif.commit_data = '0;
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_cnt", mismatch_cnt, 0);
        chk("rst_ff", first_fail, 64'h3FF);
        chk("rst_idx", entry_idx, 0);

        load(0, 64'h00, 1'b0, 5'd0, 64'd0);
        load(1, 64'h18, 1'b1, 5'd2, 64'd26);
        load(2, 64'h1C, 1'b1, 5'd30, 64'h20);

        // 1: exact trace
        go(3);
        chk("t1_busy", busy, 1);
        good_trace();
        chk("t1_idx", entry_idx, 3);
        chk("t1_notdone", done, 0);
        tick();
        chk("t1_done", done, 1);
        chk("t1_pass", pass, 1);
        chk("t1_cnt", mismatch_cnt, 0);
        chk("t1_ff", first_fail, 64'h3FF);

        // 2: branch not taken
        go(3);
        commit(64'h00, 1'b0, 5'd0, 64'd0);
        commit(64'h04, 1'b1, 5'd2, 64'd26);
        commit(64'h1C, 1'b1, 5'd30, 64'h20);
        tick();
        chk("t2_done", done, 1);
        chk("t2_cnt", mismatch_cnt, 1);
        chk("t2_ff", first_fail, 1);
        chk("t2_pass", pass, 0);

        // 3: XZR write normalised, bad data at entry 1
        go(3);
        commit(64'h00, 1'b1, 5'd31, 64'd7);
        chk("t3_xzr", mismatch_cnt, 0);
        commit(64'h18, 1'b1, 5'd2, 64'd25);
        commit(64'h1C, 1'b1, 5'd30, 64'h20);
        tick();
        chk("t3_cnt", mismatch_cnt, 1);
        chk("t3_ff", first_fail, 1);
        chk("t3_pass", pass, 0);

        // 4: timeout after 16 idle cycles
        go(3);
        commit(64'h00, 1'b0, 5'd0, 64'd0);
        for (int i = 0; i < 15; i++) tick();
        chk("t4_early_to", timeout, 0);
        chk("t4_early_busy", busy, 1);
        tick();
        chk("t4_to", timeout, 1);
        chk("t4_done", done, 1);
        chk("t4_idx", entry_idx, 1);
        chk("t4_pass", pass, 0);

        // 5: reset mid-run, then rerun on retained trace
        go(3);
        commit(64'h00, 1'b0, 5'd0, 64'd0);
        commit(64'h18, 1'b1, 5'd2, 64'd99);
        chk("t5_precnt", mismatch_cnt, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5_busy", busy, 0);
        chk("t5_done", done, 0);
        chk("t5_cnt", mismatch_cnt, 0);
        chk("t5_idx", entry_idx, 0);
        chk("t5_ff", first_fail, 64'h3FF);
        go(3);
        good_trace();
        tick();
        chk("t5_pass", pass, 1);

        // 6: empty trace, then counter saturation
        go(0);
        chk("t6_len0_busy", busy, 1);
        tick();
        chk("t6_len0_done", done, 1);
        chk("t6_len0_pass", pass, 1);
        for (int i = 0; i < 300; i++) load(i, 64'(i), 1'b0, 5'd0, 64'd0);
        go(300);
        for (int i = 0; i < 300; i++)
            commit(64'(i + 1), 1'b0, 5'd0, 64'd0);
        tick();
        chk("t6_done", done, 1);
        chk("t6_sat", mismatch_cnt, 255);
        chk("t6_ff", first_fail, 0);
        chk("t6_idx", entry_idx, 300);
        chk("t6_pass", pass, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
